core_sequencer: RTL and testbench

Per-core control FSM that drives core_state through the fetch/decode/request/wait/execute/update instruction cycle. It owns the core's shared PC and gates progress on the fetcher and on every active thread's LSU. It consumes decoded control signals and retires the block on RET. It also flags thread PC divergence and counts retired instructions. One instance per core, alongside the decoder, fetcher, LSUs and per-thread PC units.

---
 rtl/states_pkg.sv | 24 ++
 rtl/sequencer_thread_monitor.sv | 25 ++
 rtl/core_sequencer.sv | 98 +++++++++
 tb/tb_core_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/states_pkg.sv
// states_pkg: state encodings shared by the sequencer, decoder, fetcher and LSUs.
package states_pkg;
  typedef enum logic [2:0] {
    CS_IDLE    = 3'd0,
    CS_FETCH   = 3'd1,
    CS_DECODE  = 3'd2,
    CS_REQUEST = 3'd3,
    CS_WAIT    = 3'd4,
    CS_EXECUTE = 3'd5,
    CS_UPDATE  = 3'd6,
    CS_DONE    = 3'd7
  } core_state_t;
  typedef enum logic [2:0] {
    FS_IDLE     = 3'd0,
    FS_FETCHING = 3'd1,
    FS_FETCHED  = 3'd2
  } fetcher_state_t;
  typedef enum logic [1:0] {
    LS_IDLE       = 2'd0,
    LS_REQUESTING = 2'd1,
    LS_WAITING    = 2'd2,
    LS_DONE       = 2'd3
  } lsu_state_t;
endpackage

// File: rtl/sequencer_thread_monitor.sv
// sequencer_thread_monitor: per-thread LSU-busy and PC-divergence reduction over the active threads.
module sequencer_thread_monitor
  import states_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8,
  localparam int CW               = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic [CW-1:0]                          active,
  input  logic [2*THREADS_PER_BLOCK-1:0]         lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0]   next_pc,
  output logic                                   lsu_busy,
  output logic                                   pc_mismatch
);
  logic [THREADS_PER_BLOCK-1:0] busy_v, mism_v;
  for (genvar t = 0; t < THREADS_PER_BLOCK; t++) begin : g_thr
    lsu_state_t ls;
    assign ls        = lsu_state_t'(lsu_state[2*t +: 2]);
    assign busy_v[t] = (CW'(t) < active) && (ls == LS_REQUESTING || ls == LS_WAITING);
    assign mism_v[t] = (t != 0) && (CW'(t) < active) &&
                       (next_pc[PC_BITS*t +: PC_BITS] != next_pc[PC_BITS-1:0]);
  end
  assign lsu_busy    = |busy_v;
  assign pc_mismatch = |mism_v;
endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: per-core fetch/decode/request/wait/execute/update FSM owning the shared PC.
module core_sequencer
  import states_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8,
  parameter int ICOUNT_BITS       = 16,
  localparam int CW               = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [CW-1:0]                        thread_count,
  input  logic                                 decoded_mem_read_enable,
  input  logic                                 decoded_mem_write_enable,
  input  logic                                 decoded_ret,
  input  logic [2:0]                           fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                           core_state,
  output logic [PC_BITS-1:0]                   current_pc,
  output logic                                 done,
  output logic                                 diverged,
  output logic [ICOUNT_BITS-1:0]               instr_count
);
  core_state_t            state_q, state_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic [ICOUNT_BITS-1:0] cnt_q, cnt_d;
  logic [CW-1:0]          active_q, active_d, clamped;
  logic                   done_q, done_d, div_q, div_d;
  logic                   lsu_busy, pc_mismatch, unused_ok;
  // WAIT already tracks the LSUs directly, so the memory-op flags carry no extra information here.
  assign unused_ok = ^{decoded_mem_read_enable, decoded_mem_write_enable};
  assign clamped   = (thread_count > CW'(THREADS_PER_BLOCK)) ? CW'(THREADS_PER_BLOCK) : thread_count;
  sequencer_thread_monitor #(
    .THREADS_PER_BLOCK(THREADS_PER_BLOCK),
    .PC_BITS          (PC_BITS)
  ) u_mon (
    .active     (active_q),
    .lsu_state  (lsu_state),
    .next_pc    (next_pc),
    .lsu_busy   (lsu_busy),
    .pc_mismatch(pc_mismatch)
  );
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = done_q;
    div_d    = div_q;
    case (state_q)
      CS_IDLE, CS_DONE: if (start) begin
        active_d = clamped;
        pc_d     = '0;
        cnt_d    = '0;
        div_d    = 1'b0;
        done_d   = (clamped == '0);
        state_d  = (clamped == '0) ? CS_DONE : CS_FETCH;
      end
      CS_FETCH:   state_d = (fetcher_state == FS_FETCHED) ? CS_DECODE : CS_FETCH;
      CS_DECODE:  state_d = CS_REQUEST;
      CS_REQUEST: state_d = CS_WAIT;
      CS_WAIT:    state_d = lsu_busy ? CS_WAIT : CS_EXECUTE;
      CS_EXECUTE: state_d = CS_UPDATE;
      CS_UPDATE: begin
        div_d   = div_q | pc_mismatch;
        state_d = decoded_ret ? CS_DONE : CS_FETCH;
        done_d  = decoded_ret;
        pc_d    = decoded_ret ? pc_q : next_pc[PC_BITS-1:0];
        cnt_d   = (decoded_ret || &cnt_q) ? cnt_q : cnt_q + ICOUNT_BITS'(1);
      end
      default:    state_d = CS_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CS_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
      div_q    <= div_d;
    end
  end
  assign core_state  = state_q;
  assign current_pc  = pc_q;
  assign done        = done_q;
  assign diverged    = div_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: table-driven plus hand-sequenced checks of core_sequencer through a scoreboard queue.
module tb_core_sequencer;
  import states_pkg::*;
  logic        clk = 1'b0;
  logic        reset, start, rd_en, wr_en, ret;
  logic [2:0]  thread_count, fetcher_state, cs;
  logic [7:0]  lsu_state, pc;
  logic [31:0] next_pc;
  logic        done, diverged;
  logic [15:0] icount;
  typedef struct {
    string       name;
    logic        rst, st, ret;
    logic [2:0]  tc, fs, es;
    logic [7:0]  lsu, epc;
    logic [31:0] npc;
    logic        ed, ediv;
    logic [15:0] ecnt;
  } vec_t;
  vec_t        exp_q[$];
  vec_t        tbl[11];
  int          n_vec = 0, n_bad = 0;
  logic [7:0]  cpc;
  logic [15:0] ccnt;
  logic        cdiv;
  always #5 clk = ~clk;
  core_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .thread_count            (thread_count),
    .decoded_mem_read_enable (rd_en),
    .decoded_mem_write_enable(wr_en),
    .decoded_ret             (ret),
    .fetcher_state           (fetcher_state),
    .lsu_state               (lsu_state),
    .next_pc                 (next_pc),
    .core_state              (cs),
    .current_pc              (pc),
    .done                    (done),
    .diverged                (diverged),
    .instr_count             (icount)
  );
  function automatic vec_t mk(string n, logic r, logic s, logic [2:0] tc, logic [2:0] fs, logic [7:0] lsu,
                              logic [31:0] npc, logic rt, logic [2:0] es, logic [7:0] epc, logic ed,
                              logic ediv, logic [15:0] ecnt);
    vec_t v;
    v.name = n; v.rst = r; v.st = s; v.tc = tc; v.fs = fs; v.lsu = lsu; v.npc = npc; v.ret = rt;
    v.es = es; v.epc = epc; v.ed = ed; v.ediv = ediv; v.ecnt = ecnt;
    return v;
  endfunction
  task automatic apply(input vec_t v);
    vec_t e;
    reset = v.rst; start = v.st; thread_count = v.tc; fetcher_state = v.fs;
    lsu_state = v.lsu; next_pc = v.npc; ret = v.ret;
    rd_en = (v.lsu != 8'h00); wr_en = 1'b0;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if ({cs, pc, done, diverged, icount} !== {e.es, e.epc, e.ed, e.ediv, e.ecnt}) begin
      n_bad++;
      $display("FAIL %s: got state=%0d pc=%0d done=%0b div=%0b cnt=%0d, want state=%0d pc=%0d done=%0b div=%0b cnt=%0d",
               e.name, cs, pc, done, diverged, icount, e.es, e.epc, e.ed, e.ediv, e.ecnt);
    end
  endtask
  task automatic s(input string n, input logic r, input logic st, input logic [2:0] tc, input logic [2:0] fs,
                   input logic [7:0] lsu, input logic [31:0] npc, input logic rt, input logic [2:0] es,
                   input logic ed);
    apply(mk(n, r, st, tc, fs, lsu, npc, rt, es, cpc, ed, cdiv, ccnt));
  endtask
  task automatic to_wait(input string n);
    s({n, "_fetched"}, 0, 0, 0, FS_FETCHED, 0, 0, 0, CS_DECODE, 0);
    s({n, "_decode"}, 0, 0, 0, FS_IDLE, 0, 0, 0, CS_REQUEST, 0);
    s({n, "_request"}, 0, 0, 0, FS_IDLE, 0, 0, 0, CS_WAIT, 0);
  endtask
  task automatic clear_track();
    cpc = 0; ccnt = 0; cdiv = 0;
  endtask
  initial begin
    tbl[0]  = mk("reset", 1, 0, 0, FS_IDLE, 0, 0, 0, CS_IDLE, 0, 0, 0, 0);
    tbl[1]  = mk("start", 0, 1, 4, FS_IDLE, 0, 0, 0, CS_FETCH, 0, 0, 0, 0);
    tbl[2]  = mk("fetching1", 0, 0, 4, FS_FETCHING, 0, 0, 0, CS_FETCH, 0, 0, 0, 0);
    tbl[3]  = mk("fetching2", 0, 0, 4, FS_FETCHING, 0, 0, 0, CS_FETCH, 0, 0, 0, 0);
    tbl[4]  = mk("fetching3", 0, 0, 4, FS_FETCHING, 0, 0, 0, CS_FETCH, 0, 0, 0, 0);
    tbl[5]  = mk("fetched", 0, 0, 4, FS_FETCHED, 0, 0, 0, CS_DECODE, 0, 0, 0, 0);
    tbl[6]  = mk("decode", 0, 0, 4, FS_IDLE, 0, 0, 0, CS_REQUEST, 0, 0, 0, 0);
    tbl[7]  = mk("request", 0, 0, 4, FS_IDLE, 0, 0, 0, CS_WAIT, 0, 0, 0, 0);
    tbl[8]  = mk("wait", 0, 0, 4, FS_IDLE, 0, 0, 0, CS_EXECUTE, 0, 0, 0, 0);
    tbl[9]  = mk("execute", 0, 0, 4, FS_IDLE, 0, 0, 0, CS_UPDATE, 0, 0, 0, 0);
    tbl[10] = mk("update", 0, 0, 4, FS_IDLE, 0, 32'h01010101, 0, CS_FETCH, 1, 0, 0, 1);
    for (int i = 0; i < 11; i++) apply(tbl[i]);
    cpc = 1; ccnt = 1; cdiv = 0;
    // Slow load: thread 2 finishes five cycles after the others.
    to_wait("ld");
    s("ld_wait_req", 0, 0, 0, FS_IDLE, 8'h55, 0, 0, CS_WAIT, 0);
    for (int i = 0; i < 5; i++) s("ld_wait_slow", 0, 0, 0, FS_IDLE, 8'hEF, 0, 0, CS_WAIT, 0);
    s("ld_wait_done", 0, 0, 0, FS_IDLE, 8'hFF, 0, 0, CS_EXECUTE, 0);
    s("ld_exec", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_UPDATE, 0);
    cpc = 2; ccnt = 2;
    s("ld_update", 0, 0, 0, FS_IDLE, 0, 32'h02020202, 0, CS_FETCH, 0);
    clear_track();
    s("rst2", 1, 0, 0, FS_IDLE, 0, 0, 0, CS_IDLE, 0);
    s("start_tc2", 0, 1, 2, FS_FETCHED, 0, 0, 0, CS_FETCH, 0);
    to_wait("tc2");
    s("inactive_busy", 0, 0, 0, FS_IDLE, 8'h80, 0, 0, CS_EXECUTE, 0);
    s("tc2_exec", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_UPDATE, 0);
    cpc = 3; ccnt = 1;
    s("inactive_div", 0, 0, 0, FS_IDLE, 0, 32'h09000303, 0, CS_FETCH, 0);
    clear_track();
    s("rst3", 1, 0, 0, FS_IDLE, 0, 0, 0, CS_IDLE, 0);
    s("start_tc6", 0, 1, 6, FS_IDLE, 0, 0, 0, CS_FETCH, 0);
    to_wait("tc6");
    s("clamp_busy", 0, 0, 0, FS_IDLE, 8'h80, 0, 0, CS_WAIT, 0);
    s("clamp_free", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_EXECUTE, 0);
    s("tc6_exec", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_UPDATE, 0);
    cpc = 3; ccnt = 1; cdiv = 1;
    s("clamp_div", 0, 0, 0, FS_IDLE, 0, 32'h09000303, 0, CS_FETCH, 0);
    clear_track();
    s("rst4", 1, 0, 0, FS_IDLE, 0, 0, 0, CS_IDLE, 0);
    s("start_tc3", 0, 1, 3, FS_IDLE, 0, 0, 0, CS_FETCH, 0);
    to_wait("dv1");
    s("dv1_wait", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_EXECUTE, 0);
    s("dv1_exec", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_UPDATE, 0);
    cpc = 5; ccnt = 1; cdiv = 1;
    s("diverge", 0, 0, 0, FS_IDLE, 0, 32'h09070505, 0, CS_FETCH, 0);
    to_wait("dv2");
    s("dv2_wait", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_EXECUTE, 0);
    s("dv2_exec", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_UPDATE, 0);
    cpc = 6; ccnt = 2;
    s("div_sticky", 0, 0, 0, FS_IDLE, 0, 32'h06060606, 0, CS_FETCH, 0);
    to_wait("dv3");
    s("dv3_wait", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_EXECUTE, 0);
    s("dv3_exec", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_UPDATE, 0);
    cpc = 7; ccnt = 3;
    s("third_instr", 0, 0, 0, FS_IDLE, 0, 32'h07070707, 0, CS_FETCH, 0);
    to_wait("ret");
    s("ret_wait", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_EXECUTE, 0);
    s("ret_exec", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_UPDATE, 0);
    s("ret_update", 0, 0, 0, FS_IDLE, 0, 32'h08080808, 1, CS_DONE, 1);
    s("done_hold", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_DONE, 1);
    clear_track();
    s("restart", 0, 1, 4, FS_FETCHING, 0, 0, 0, CS_FETCH, 0);
    s("start_ignored", 0, 1, 4, FS_FETCHING, 0, 0, 0, CS_FETCH, 0);
    to_wait("rw");
    s("rw_wait", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_EXECUTE, 0);
    s("rw_exec", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_UPDATE, 0);
    cpc = 4; ccnt = 1;
    s("rw_update", 0, 0, 0, FS_IDLE, 0, 32'h04040404, 0, CS_FETCH, 0);
    to_wait("rw2");
    s("rw2_busy", 0, 0, 0, FS_IDLE, 8'h55, 0, 0, CS_WAIT, 0);
    clear_track();
    s("reset_in_wait", 1, 0, 0, FS_IDLE, 8'h55, 0, 0, CS_IDLE, 0);
    s("start_tc0", 0, 1, 0, FS_IDLE, 0, 0, 0, CS_DONE, 1);
    s("tc0_hold", 0, 0, 0, FS_IDLE, 0, 0, 0, CS_DONE, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
